// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings, data width and line idle level.
// Used by both the transmitter (uart_txd) and the receiver.
package uart_pkg;

  localparam int   UART_DATA_W     = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_txd.sv
// UART transmitter: one byte per request, start + 8 data bits LSB first + optional parity + stop bit(s).
// Define UART_TXD_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD) after the data bits.
module uart_txd
  import uart_pkg::*;
#(
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_tx_start,
  input  logic [UART_DATA_W-1:0] i_data,
  input  logic                   i_baudrate_tx_clk,
  output logic                   o_rs232_txd,
  output logic                   o_baudrate_tx_clk_en,
  output logic                   o_tx_ready,
  output logic                   o_tx_done
);

  localparam int          CNT_W     = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(UART_DATA_W - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_txd: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_txd: PARITY_ODD must be 0 or 1");
  end

  uart_state_e            state_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   stop_cnt_q;
  logic                   txd_q;
  logic                   clk_en_q;
  logic                   ready_q;
  logic                   done_q;
`ifdef UART_TXD_PARITY_EN
  logic                   parity_q;
`endif

  // NOTE: every register here is sequential state, so it is assigned with <= only;
  // the async reset drives the line idle immediately, which abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= UART_IDLE_LEVEL;
      clk_en_q   <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TXD_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Ticks are not looked at here, so a stray tick in the accept cycle is harmless.
          if (i_tx_start && ready_q) begin
            shift_q    <= i_data;
            stop_cnt_q <= 1'b0;
            state_q    <= START;
            txd_q      <= 1'b0;
            clk_en_q   <= 1'b1;
            ready_q    <= 1'b0;
`ifdef UART_TXD_PARITY_EN
            parity_q   <= (^i_data) ^ (PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          if (i_baudrate_tx_clk) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            txd_q     <= shift_q[0];
          end
        end
        DATA: begin
          if (i_baudrate_tx_clk) begin
            shift_q   <= {1'b0, shift_q[UART_DATA_W-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TXD_PARITY_EN
              state_q <= PARITY;
              txd_q   <= parity_q;
`else
              state_q <= STOP;
              txd_q   <= UART_IDLE_LEVEL;
`endif
            end else begin
              txd_q <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (i_baudrate_tx_clk) begin
            state_q <= STOP;
            txd_q   <= UART_IDLE_LEVEL;
          end
        end
        STOP: begin
          if (i_baudrate_tx_clk) begin
            if (stop_cnt_q == STOP_LAST) begin
              state_q    <= IDLE;
              stop_cnt_q <= 1'b0;
              clk_en_q   <= 1'b0;
              ready_q    <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          txd_q    <= UART_IDLE_LEVEL;
          clk_en_q <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign o_rs232_txd          = txd_q;
  assign o_baudrate_tx_clk_en = clk_en_q;
  assign o_tx_ready           = ready_q;
  assign o_tx_done            = done_q;

endmodule
